// File: rtl/exc_pkg.sv
// Shared types and helpers for the exception request controller.
package exc_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    HANDLER
  } exc_state_t;

  localparam int unsigned ESTATUS_NONE = 0;

  // EStatus code for a source index: index + 1, leaving 0 as "none".
  function automatic int unsigned src_to_status(input int unsigned idx);
    return idx + 1;
  endfunction

endpackage

// File: rtl/exc_request_ctrl_sync_edge.sv
// Two-flop synchroniser followed by a rising-edge detector for an asynchronous request line.
module sync_edge (
  input  logic clk,
  input  logic reset,
  input  logic async_i,
  output logic rise_o
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  // Synchroniser chain plus one delayed copy for edge detection.
  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= async_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign rise_o = sync_q & ~prev_q;

endmodule

// File: rtl/exc_request_ctrl.sv
// Exception request initiator: sticky pending sources, fixed-priority selection, and the
// Exc/ExcAck/ERet handshake towards the exception capture unit.
module exc_request_ctrl
  import exc_pkg::*;
#(
  parameter int unsigned N_SRC    = 4,
  parameter int unsigned STATUS_W = 4,
  parameter int unsigned EXT_SRC  = 3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [N_SRC-1:0]    src_i,
  input  logic [N_SRC-1:0]    mask_i,
  input  logic                ExcAck,
  input  logic                ERet,
  output logic                Exc,
  output logic [STATUS_W-1:0] EStatus,
  output logic [N_SRC-1:0]    pending_o,
  output logic                busy_o
);

  localparam int unsigned SEL_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;

  exc_state_t          state_q, state_d;
  logic [SEL_W-1:0]    sel_q, sel_d;
  logic                exc_q, exc_d;
  logic [STATUS_W-1:0] estatus_q, estatus_d;
  logic [N_SRC-1:0]    pending_q, pending_d;
  logic                busy_q, busy_d;

  logic                ext_rise;
  logic [N_SRC-1:0]    src_eff;
  logic [N_SRC-1:0]    req;
  logic [N_SRC-1:0]    clr;
  int unsigned         sel_idx;

  sync_edge u_ext_sync (
    .clk     (clk),
    .reset   (reset),
    .async_i (src_i[EXT_SRC]),
    .rise_o  (ext_rise)
  );

  // Effective set vector: the external line contributes only its synchronised rising edge.
  always_comb begin
    src_eff          = src_i;
    src_eff[EXT_SRC] = ext_rise;
  end

  // Fixed-priority encoder over enabled pending sources; lowest index wins.
  always_comb begin
    req     = pending_q & mask_i;
    sel_idx = 0;
    for (int unsigned i = N_SRC; i > 0; i--) begin
      if (req[i-1]) sel_idx = i - 1;
    end
  end

  // Handshake FSM next state, output next values and pending update (set beats clear).
  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    exc_d     = exc_q;
    estatus_d = estatus_q;
    clr       = '0;
    case (state_q)
      IDLE: begin
        if (|req) begin
          state_d   = REQ;
          sel_d     = SEL_W'(sel_idx);
          exc_d     = 1'b1;
          estatus_d = STATUS_W'(src_to_status(sel_idx));
        end
      end
      REQ: begin
        if (ExcAck) begin
          state_d    = HANDLER;
          exc_d      = 1'b0;
          clr[sel_q] = 1'b1;
        end
      end
      HANDLER: begin
        if (ERet) begin
          state_d   = IDLE;
          estatus_d = STATUS_W'(ESTATUS_NONE);
        end
      end
      default: begin
        state_d   = IDLE;
        exc_d     = 1'b0;
        estatus_d = STATUS_W'(ESTATUS_NONE);
      end
    endcase
    pending_d = (pending_q & ~clr) | src_eff;
    busy_d    = (state_d != IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      sel_q     <= '0;
      exc_q     <= 1'b0;
      estatus_q <= '0;
      pending_q <= '0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      exc_q     <= exc_d;
      estatus_q <= estatus_d;
      pending_q <= pending_d;
      busy_q    <= busy_d;
    end
  end

  assign Exc       = exc_q;
  assign EStatus   = estatus_q;
  assign pending_o = pending_q;
  assign busy_o    = busy_q;

endmodule
